// File: rtl/char_box_locate.sv
// char_box_locate: finds one character's bounding box inside a search window, once per frame.
// Optional BOX_HOLD_EN: a rejected box keeps the previous char_* instead of reporting the window.
module char_box_locate #(
  parameter int MIN_ROW_PIX = 2,
  parameter int MIN_W       = 30,
  parameter int MIN_H       = 45
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [23:0] i_data,
  input  logic        i_th,
  input  logic [11:0] win_left,
  input  logic [11:0] win_right,
  input  logic [11:0] win_up,
  input  logic [11:0] win_down,
  output logic [11:0] char_left,
  output logic [11:0] char_right,
  output logic [11:0] char_up,
  output logic [11:0] char_down,
  output logic        box_valid,
  output logic        box_done,
  output logic [23:0] o_data,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_th,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de
);
  localparam logic [7:0]  MIN_HITS = 8'(MIN_ROW_PIX);
  localparam logic [12:0] MIN_W13  = 13'(MIN_W);
  localparam logic [12:0] MIN_H13  = 13'(MIN_H);
  logic        in_win, row_first, row_last, commit, vs_rise, frame_end, ok;
  logic [11:0] row_min_q, row_min_d, row_max_q, row_max_d;
  logic [7:0]  row_hits_q, row_hits_d;
  logic [11:0] f_left_q, f_left_d, f_right_q, f_right_d, f_up_q, f_up_d, f_down_q, f_down_d;
  logic        f_any_q, f_any_d;
  logic        vs_d_q, vs_seen_q, armed_q;
  logic [12:0] box_w, box_h;
  always_comb begin
    in_win     = i_de && (win_left <= i_x) && (i_x <= win_right) && (win_up <= i_y) && (i_y <= win_down);
    row_first  = in_win && (i_x == win_left);
    row_last   = in_win && (i_x == win_right);
    row_min_d  = row_first ? (i_th ? i_x : 12'hFFF)
               : (in_win && i_th && (i_x < row_min_q)) ? i_x : row_min_q;
    row_max_d  = row_first ? (i_th ? i_x : 12'h000)
               : (in_win && i_th && (i_x > row_max_q)) ? i_x : row_max_q;
    row_hits_d = row_first ? {7'd0, i_th}
               : (in_win && i_th && (row_hits_q != 8'hFF)) ? row_hits_q + 8'd1 : row_hits_q;
    commit     = row_last && (row_hits_d >= MIN_HITS);
    f_up_d     = !i_vs ? 12'h000 : (commit && !f_any_q) ? i_y : f_up_q;
    f_down_d   = !i_vs ? 12'h000 : commit ? i_y : f_down_q;
    f_left_d   = !i_vs ? 12'hFFF : (commit && (row_min_d < f_left_q)) ? row_min_d : f_left_q;
    f_right_d  = !i_vs ? 12'h000 : (commit && (row_max_d > f_right_q)) ? row_max_d : f_right_q;
    f_any_d    = i_vs && (f_any_q || commit);
    // vs_d is only trusted once it holds a real sample, so a frame in flight at reset never arms
    vs_rise    = vs_seen_q && !vs_d_q && i_vs;
    frame_end  = armed_q && vs_d_q && !i_vs;
    box_w      = {1'b0, f_right_q} - {1'b0, f_left_q} + 13'd1;
    box_h      = {1'b0, f_down_q} - {1'b0, f_up_q} + 13'd1;
    ok         = f_any_q && (box_w >= MIN_W13) && (box_h >= MIN_H13);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_min_q  <= 12'h000;
      row_max_q  <= 12'h000;
      row_hits_q <= 8'd0;
      f_left_q   <= 12'hFFF;
      f_right_q  <= 12'h000;
      f_up_q     <= 12'h000;
      f_down_q   <= 12'h000;
      f_any_q    <= 1'b0;
      vs_d_q     <= 1'b0;
      vs_seen_q  <= 1'b0;
      armed_q    <= 1'b0;
      char_left  <= 12'h000;
      char_right <= 12'h000;
      char_up    <= 12'h000;
      char_down  <= 12'h000;
      box_valid  <= 1'b0;
      box_done   <= 1'b0;
      o_data     <= 24'h000000;
      o_x        <= 12'h000;
      o_y        <= 12'h000;
      o_th       <= 1'b0;
      o_hs       <= 1'b0;
      o_vs       <= 1'b0;
      o_de       <= 1'b0;
    end else begin
      row_min_q  <= row_min_d;
      row_max_q  <= row_max_d;
      row_hits_q <= row_hits_d;
      f_left_q   <= f_left_d;
      f_right_q  <= f_right_d;
      f_up_q     <= f_up_d;
      f_down_q   <= f_down_d;
      f_any_q    <= f_any_d;
      vs_d_q     <= i_vs;
      vs_seen_q  <= 1'b1;
      armed_q    <= armed_q || vs_rise;
      box_done   <= frame_end;
      if (frame_end) begin
        box_valid <= ok;
        if (ok) begin
          char_left  <= f_left_q;
          char_right <= f_right_q;
          char_up    <= f_up_q;
          char_down  <= f_down_q;
        end
`ifndef BOX_HOLD_EN
        else begin
          char_left  <= win_left;
          char_right <= win_right;
          char_up    <= win_up;
          char_down  <= win_down;
        end
`endif
      end
      o_data <= i_data;
      o_x    <= i_x;
      o_y    <= i_y;
      o_th   <= i_th;
      o_hs   <= i_hs;
      o_vs   <= i_vs;
      o_de   <= i_de;
    end
  end
endmodule

// File: tb/tb_char_box_locate.sv
// tb_char_box_locate: frame table driven through char_box_locate, boxes checked via a scoreboard queue.
module tb_char_box_locate;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_hs = 0, i_vs = 0, i_de = 0, i_th = 0;
  logic [11:0] i_x = 0, i_y = 0, win_left = 0, win_right = 0, win_up = 0, win_down = 0;
  logic [23:0] i_data = 0;
  logic [11:0] char_left, char_right, char_up, char_down, o_x, o_y;
  logic        box_valid, box_done, o_th, o_hs, o_vs, o_de;
  logic [23:0] o_data;
`ifdef BOX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  typedef struct {
    logic [11:0] wl, wr, wu, wd, bx0, bx1, by0, by1;
    bit          noise, rst_mid, exp_done, exp_valid;
    logic [11:0] el, er, eu, ed;
  } frame_t;
  typedef struct {
    logic        valid;
    logic [11:0] l, r, u, d;
  } box_t;
  box_t   sb[$];
  frame_t frames[6];
  int     checks = 0, failures = 0, done_seen = 0, done_exp = 0;
  bit     mon_en = 1'b1;

  char_box_locate dut (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y),
    .i_data(i_data), .i_th(i_th), .win_left(win_left), .win_right(win_right), .win_up(win_up),
    .win_down(win_down), .char_left(char_left), .char_right(char_right), .char_up(char_up),
    .char_down(char_down), .box_valid(box_valid), .box_done(box_done), .o_data(o_data),
    .o_x(o_x), .o_y(o_y), .o_th(o_th), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t mk(input int wl, wr, wu, wd, bx0, bx1, by0, by1,
                                input bit noise, rst_mid, exp_done, exp_valid,
                                input int el, er, eu, ed);
    frame_t f;
    f.wl = 12'(wl); f.wr = 12'(wr); f.wu = 12'(wu); f.wd = 12'(wd);
    f.bx0 = 12'(bx0); f.bx1 = 12'(bx1); f.by0 = 12'(by0); f.by1 = 12'(by1);
    f.noise = noise; f.rst_mid = rst_mid; f.exp_done = exp_done; f.exp_valid = exp_valid;
    f.el = 12'(el); f.er = 12'(er); f.eu = 12'(eu); f.ed = 12'(ed);
    return f;
  endfunction

  // box_done must coincide with the o_vs falling edge and last one cycle
  initial begin
    logic prev_done, prev_ovs;
    box_t e;
    prev_done = 1'b0;
    prev_ovs  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && box_done) begin
        done_seen++;
        chk("done_align", {62'd0, prev_ovs, o_vs}, 64'd2);
        chk("done_pulse", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_box_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          chk("box_valid", {63'd0, box_valid}, {63'd0, e.valid});
          chk("box_lrud", {16'd0, char_left, char_right, char_up, char_down},
              {16'd0, e.l, e.r, e.u, e.d});
        end
      end
      prev_done = box_done;
      prev_ovs  = o_vs;
    end
  end

  task automatic check_zero(input string name);
    chk(name, {char_left, char_right, char_up, char_down, box_valid, box_done, o_vs, o_de, o_th, o_hs},
        64'd0);
    chk({name, "_pass"}, {16'd0, o_data, o_x, o_y}, 64'd0);
  endtask

  task automatic drive_frame(input frame_t f);
    box_t b;
    win_left = f.wl; win_right = f.wr; win_up = f.wu; win_down = f.wd;
    i_vs = 0; i_de = 0; i_th = 0; i_hs = 0;
    repeat (3) step();
    if (f.exp_done) begin
      b.valid = f.exp_valid; b.l = f.el; b.r = f.er; b.u = f.eu; b.d = f.ed;
      sb.push_back(b);
      done_exp++;
    end
    i_vs = 1;
    repeat (3) step();
    for (int y = 45; y <= 145; y++) begin
      i_de = 0; i_th = 0; i_hs = 1;
      if (f.rst_mid && y == 90) begin
        rst_n = 0;
        #1;
        check_zero("rst_mid");
        step();
        step();
        rst_n = 1;
      end
      repeat (2) step();
      i_hs = 0;
      for (int x = 95; x <= 170; x++) begin
        i_de   = 1;
        i_x    = 12'(x);
        i_y    = 12'(y);
        i_data = 24'($urandom);
        i_th   = (x >= int'(f.bx0) && x <= int'(f.bx1) && y >= int'(f.by0) && y <= int'(f.by1)) ||
                 (f.noise && ((x == 105 && y == 55) || (x == 158 && y == 138)));
        step();
      end
    end
    i_de = 0; i_th = 0; i_vs = 0;
    repeat (4) step();
  endtask

  initial begin
    frames[0] = mk(100, 160, 50, 140, 110, 163, 60, 134, 0, 0, 1, 1, 110, 160, 60, 134);
    frames[1] = mk(100, 160, 50, 140, 110, 163, 60, 134, 1, 0, 1, 1, 110, 160, 60, 134);
    frames[2] = mk(100, 160, 50, 140, 120, 139, 60, 134, 0, 0, 1, 0,
                   HOLD ? 110 : 100, 160, HOLD ? 60 : 50, HOLD ? 134 : 140);
    frames[3] = mk(200, 100, 50, 140, 95, 170, 45, 145, 0, 0, 1, 0,
                   HOLD ? 110 : 200, HOLD ? 160 : 100, HOLD ? 60 : 50, HOLD ? 134 : 140);
    frames[4] = mk(100, 160, 50, 140, 110, 163, 60, 134, 0, 1, 0, 0, 0, 0, 0, 0);
    frames[5] = mk(100, 160, 50, 140, 110, 163, 60, 134, 0, 0, 1, 1, 110, 160, 60, 134);
    i_vs = 1;
    i_de = 1;
    repeat (3) step();
    check_zero("reset");
    rst_n = 1;
    step();
    for (int i = 0; i < 6; i++) drive_frame(frames[i]);
    chk("done_count", 64'(done_seen), 64'(done_exp));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    mon_en = 0;
    for (int i = 0; i < 200; i++) begin
      logic [51:0] v;
      v = {24'($urandom), 12'($urandom), 12'($urandom), 4'($urandom)};
      {i_data, i_x, i_y, i_th, i_hs, i_vs, i_de} = v;
      step();
      chk("passthru", {12'd0, o_data, o_x, o_y, o_th, o_hs, o_vs, o_de}, {12'd0, v});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
